boole_vector_driver: RTL and testbench
======================================

Name: boole_vector_driver

Overview:
- Sequential stimulus/response engine for the 4-input boolean expression block (f = any input high, g = all inputs high, h = NOT exactly-two-high).
- On a start pulse it drives all 16 input combinations on a/b/c/d and samples the block's f/g/h after a settle delay.
- Each sample is compared against an internal golden model; the block reports error count, first failing vector and pass/fail.
- Sits beside the expression block on the board/bench: its outputs feed the expression inputs, and the expression outputs return here.

Parameters:
- SETTLE_CYCLES, 2, cycles each vector is held before sampling; legal range >= 1.
- ERR_W, 5, width of the error counter; default holds 0..16 without saturating.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  run request; sampled only in IDLE.
- a  out  1  stimulus, vec[3].
- b  out  1  stimulus, vec[2].
- c  out  1  stimulus, vec[1].
- d  out  1  stimulus, vec[0].
- f_in  in  1  response f from the expression block.
- g_in  in  1  response g.
- h_in  in  1  response h.
- busy  out  1  high from the cycle after start is accepted until DONE.
- done  out  1  one-cycle pulse at end of run.
- pass  out  1  run result; updated in DONE; holds until next DONE or reset.
- err_count  out  ERR_W  mismatching vectors this run; saturates at 2^ERR_W-1.
- first_fail_vec  out  4  vec value of the first mismatch.
- first_fail_valid  out  1  high once first_fail_vec has been captured.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, vec=0, a=b=c=d=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=0, first_fail_valid=0, settle counter=0.
- Outputs a..d are registered straight from vec, with no combinational path from start.
- Golden model for vector v:
  - f = OR(v).
  - g = AND(v).
  - h = NOT(popcount(v)==2).
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE:
  - busy=0.
  - When start=1: vec<=0, cnt<=SETTLE_CYCLES-1, err_count<=0, first_fail_valid<=0, first_fail_vec<=0, then go to SETTLE.
  - pass is not cleared on start.
- SETTLE:
  - busy=1.
  - When cnt==0, go to CHECK; otherwise cnt<=cnt-1.
  - Lasts exactly SETTLE_CYCLES cycles.
- CHECK (one cycle): compare {f_in,g_in,h_in} against golden(vec).
  - On mismatch: err_count increments with saturation. If first_fail_valid==0, capture first_fail_vec<=vec and set first_fail_valid<=1.
  - If vec==15, go to DONE.
  - Otherwise vec<=vec+1, cnt<=SETTLE_CYCLES-1, go to SETTLE.
  - vec does not wrap.
- DONE (one cycle):
  - done=1, busy stays 1.
  - pass<=(err_count==0 after final CHECK).
  - Go to IDLE; vec and a..d hold the last vector.
- Latency: each vector is held for SETTLE_CYCLES+1 cycles. done asserts 16*(SETTLE_CYCLES+1)+1 cycles after the start-accept edge (49 at default).
- Boundary conditions:
  - start while busy or in DONE: ignored, with no restart and no queuing.
  - start held continuously: a new run is accepted in the first IDLE cycle after DONE.
  - Responses on f_in/g_in/h_in are only sampled in CHECK; values in other states have no effect.
  - rst mid-run: immediate return to reset values. No done pulse; the partial results are discarded.
  - err_count saturates: with ERR_W=4, 16 mismatches read 15.

Optional Feature:
- Macro: STOP_ON_ERROR_EN.
- Defined: the first mismatch in CHECK goes directly to DONE (pass<=0). vec and a..d hold the failing vector; err_count=1.
- Undefined: all 16 vectors always run, and every mismatch is counted.

Test Plan:
1. Correct combinational expression model, default parameters, 1-cycle start pulse:
   - a..d step through 0000..1111, each held 3 cycles.
   - done pulses 49 cycles after accept.
   - pass=1, err_count=0, first_fail_valid=0.
2. Model with h non-inverted (h = exactly two high), macro undefined:
   - err_count=16, first_fail_vec=0, first_fail_valid=1, pass=0.
   - Rerun with ERR_W=4 gives err_count=15.
3. Model with g stuck-at-0:
   - err_count=1, first_fail_vec=4'hF, pass=0.
   - done timing unchanged (49 cycles).
4. start re-pulsed at cycle 10 of a run:
   - Ignored; done still at cycle 49.
   - A later start clears err_count/first_fail_valid on accept, and pass keeps its old value until the new DONE.
5. rst asserted while vec=5:
   - Same cycle: a..d=0, busy=0, counters 0.
   - No done pulse.
   - A following start performs a complete 49-cycle run.
6. STOP_ON_ERROR_EN defined, f stuck-at-0:
   - vec 0 passes, vec 1 fails.
   - done 7 cycles after accept, err_count=1, first_fail_vec=1, a..d=0001, pass=0.

Source files
------------

// File: rtl/boole_vector_driver.sv
// ============================================================================
// Module   : boole_vector_driver
// Purpose  : Stimulus/response engine for the 4-input boolean expression
//            block (f = any high, g = all high, h = NOT exactly-two-high).
//            A start pulse walks vec through 0..15 on a/b/c/d. Each vector
//            is held SETTLE_CYCLES cycles and then checked for one cycle
//            against an internal golden model. The run reports an error
//            count, the first failing vector and pass/fail.
// Macro    : STOP_ON_ERROR_EN - when defined, the first mismatch ends the
//            run at once and a..d keep the failing vector.
// Ports    : clk, rst (async, active-high), start
//            a,b,c,d          stimulus outputs, vec[3..0]
//            f_in,g_in,h_in   responses from the expression block
//            busy, done       run in progress / end-of-run pulse
//            pass, err_count  run result / mismatch count (saturating)
//            first_fail_vec, first_fail_valid  first mismatching vector
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module boole_vector_driver #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  input  logic             f_in,
  input  logic             g_in,
  input  logic             h_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       first_fail_vec,
  output logic             first_fail_valid
);

  localparam int               CNT_W      = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX    = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state_q;
  logic [3:0]       vec_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [ERR_W-1:0] err_q;
  logic [3:0]       ffv_q;
  logic             ffval_q;

  logic [2:0]       w_pop;
  logic [2:0]       w_golden;
  logic             w_mismatch;
  logic             w_last;
  logic [ERR_W-1:0] err_d;

  // Golden model of the expression block for the vector currently driven.
  assign w_pop      = 3'(vec_q[0]) + 3'(vec_q[1]) + 3'(vec_q[2]) + 3'(vec_q[3]);
  assign w_golden   = {(|vec_q), (&vec_q), (w_pop != 3'd2)};
  assign w_mismatch = ({f_in, g_in, h_in} != w_golden);

  // Saturating increment of the mismatch counter.
  assign err_d = (w_mismatch && (err_q != ERR_MAX)) ? (err_q + ERR_W'(1)) : err_q;

  // Condition that ends the run from CHECK.
`ifdef STOP_ON_ERROR_EN
  assign w_last = w_mismatch || (vec_q == 4'hF);
`else
  assign w_last = (vec_q == 4'hF);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= 4'h0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ffv_q   <= 4'h0;
      ffval_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            vec_q   <= 4'h0;
            cnt_q   <= CNT_RELOAD;
            err_q   <= '0;
            ffv_q   <= 4'h0;
            ffval_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (cnt_q == '0) begin
            state_q <= S_CHECK;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_CHECK: begin
          err_q <= err_d;
          if (w_mismatch && !ffval_q) begin
            ffv_q   <= vec_q;
            ffval_q <= 1'b1;
          end
          if (w_last) begin
            // done and pass are registered on entry so both are visible
            // during the single DONE cycle.
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
            state_q <= S_DONE;
          end else begin
            vec_q   <= vec_q + 4'd1;
            cnt_q   <= CNT_RELOAD;
            state_q <= S_SETTLE;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign a                = vec_q[3];
  assign b                = vec_q[2];
  assign c                = vec_q[1];
  assign d                = vec_q[0];
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffval_q;

endmodule

`default_nettype wire

// File: tb/tb_boole_vector_driver.sv
// ============================================================================
// Module   : tb_boole_vector_driver
// Purpose  : Self-checking bench for boole_vector_driver. A model of the
//            expression block with selectable faults answers the DUT; run
//            results are queued on start and checked when done pulses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_boole_vector_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  int         mode;

  logic       a, b, c, d, f_in, g_in, h_in, busy, done, pass, ffval;
  logic [4:0] err;
  logic [3:0] ffv;

  logic       a4, b4, c4, d4, f4, g4, h4, busy4, done4, pass4, ffval4;
  logic [3:0] err4;
  logic [3:0] ffv4;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic prev_pass;

  typedef struct {
    logic       pass;
    logic [4:0] err;
    logic [3:0] err4;
    logic [3:0] ffv;
    logic       ffval;
    int         lat;
    logic [3:0] vec;
  } exp_t;

  exp_t       sbq[$];
  logic [3:0] sb4[$];

  always #5 clk = ~clk;

  boole_vector_driver u_dut (
    .clk(clk), .rst(rst), .start(start),
    .a(a), .b(b), .c(c), .d(d),
    .f_in(f_in), .g_in(g_in), .h_in(h_in),
    .busy(busy), .done(done), .pass(pass), .err_count(err),
    .first_fail_vec(ffv), .first_fail_valid(ffval)
  );

  boole_vector_driver #(.SETTLE_CYCLES(2), .ERR_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start),
    .a(a4), .b(b4), .c(c4), .d(d4),
    .f_in(f4), .g_in(g4), .h_in(h4),
    .busy(busy4), .done(done4), .pass(pass4), .err_count(err4),
    .first_fail_vec(ffv4), .first_fail_valid(ffval4)
  );

  // Expression block with injectable faults:
  // 0 correct, 1 h non-inverted, 2 g stuck-at-0, 3 f stuck-at-0.
  function automatic logic [2:0] expr(input logic [3:0] v, input int m);
    logic fo, go, ho;
    fo = |v;
    go = &v;
    ho = ($countones(v) != 2);
    if (m == 1) ho = ($countones(v) == 2);
    if (m == 2) go = 1'b0;
    if (m == 3) fo = 1'b0;
    return {fo, go, ho};
  endfunction

  assign {f_in, g_in, h_in} = expr({a, b, c, d}, mode);
  assign {f4, g4, h4}       = expr({a4, b4, c4, d4}, mode);

  // Hand-computed run results for each fault mode.
  function automatic exp_t expect_for(input int m);
    exp_t e;
`ifdef STOP_ON_ERROR_EN
    case (m)
      1:       e = '{1'b0, 5'd1,  4'd1,  4'h0, 1'b1, 4,  4'h0};
      2:       e = '{1'b0, 5'd1,  4'd1,  4'hF, 1'b1, 49, 4'hF};
      3:       e = '{1'b0, 5'd1,  4'd1,  4'h1, 1'b1, 7,  4'h1};
      default: e = '{1'b1, 5'd0,  4'd0,  4'h0, 1'b0, 49, 4'hF};
    endcase
`else
    case (m)
      1:       e = '{1'b0, 5'd16, 4'd15, 4'h0, 1'b1, 49, 4'hF};
      2:       e = '{1'b0, 5'd1,  4'd1,  4'hF, 1'b1, 49, 4'hF};
      3:       e = '{1'b0, 5'd15, 4'd15, 4'h1, 1'b1, 49, 4'hF};
      default: e = '{1'b1, 5'd0,  4'd0,  4'h0, 1'b0, 49, 4'hF};
    endcase
`endif
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Monitor: counts cycles of each run, checks the stepping of a..d and
  // pops the scoreboard whenever either DUT pulses done.
  always @(negedge clk) begin
    exp_t e;
    logic [3:0] e4;
    if (busy) cyc = cyc + 1;
    else      cyc = 0;
    if (busy && !done && cyc >= 1 && cyc <= 48)
      chk("vec_step", {a, b, c, d}, (cyc - 1) / 3);
    if (done) begin
      if (sbq.size() == 0) begin
        chk("spurious_done", done, 1'b0);
      end else begin
        e = sbq.pop_front();
        chk("pass",        pass,         e.pass);
        chk("err_count",   err,          e.err);
        chk("ffail_vec",   ffv,          e.ffv);
        chk("ffail_valid", ffval,        e.ffval);
        chk("done_lat",    cyc,          e.lat);
        chk("final_vec",   {a, b, c, d}, e.vec);
      end
    end
    if (done4) begin
      if (sb4.size() == 0) begin
        chk("spurious_done4", done4, 1'b0);
      end else begin
        e4 = sb4.pop_front();
        chk("err_count_w4", err4, e4);
      end
    end
  end

  task automatic push(input int m);
    exp_t e;
    e = expect_for(m);
    sbq.push_back(e);
    sb4.push_back(e.err4);
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 200 && sbq.size() != 0; i++) @(negedge clk);
    chk("run_completed", sbq.size(), 0);
    sbq.delete();
    sb4.delete();
  endtask

  // One run: queue its result, pulse start, check the accept-time clears,
  // optionally re-pulse start mid-run, then wait for the monitor.
  task automatic run(input int m, input int repulse_at);
    mode = m;
    push(m);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("busy_after_accept", busy, 1'b1);
    chk("err_cleared",       err, 0);
    chk("ffval_cleared",     ffval, 1'b0);
    chk("pass_held",         pass, prev_pass);
    if (repulse_at > 1) begin
      repeat (repulse_at - 1) @(negedge clk);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
    end
    wait_empty();
    prev_pass = expect_for(m).pass;
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    mode      = 0;
    prev_pass = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_abcd",  {a, b, c, d}, 4'h0);
    chk("rst_busy",  busy, 1'b0);
    chk("rst_done",  done, 1'b0);
    chk("rst_pass",  pass, 1'b0);
    chk("rst_err",   err, 0);
    chk("rst_ffv",   ffv, 0);
    chk("rst_ffval", ffval, 1'b0);
    @(negedge clk) rst = 1'b0;

    run(0, 0);   // clean block
    run(1, 0);   // h non-inverted: every vector fails
    run(2, 0);   // g stuck-at-0: only vec 15 fails
    run(0, 10);  // start re-pulsed at cycle 10 is ignored
    run(3, 0);   // f stuck-at-0

    // Reset in the middle of a run.
`ifdef STOP_ON_ERROR_EN
    mode = 0;
`else
    mode = 1;
`endif
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < 100 && {a, b, c, d} != 4'd5; i++) @(negedge clk);
    chk("reach_vec5", {a, b, c, d}, 4'd5);
    rst = 1'b1;
    #1;
    chk("midrst_abcd",  {a, b, c, d}, 4'h0);
    chk("midrst_busy",  busy, 1'b0);
    chk("midrst_err",   err, 0);
    chk("midrst_ffval", ffval, 1'b0);
    chk("midrst_ffv",   ffv, 0);
    chk("midrst_pass",  pass, 1'b0);
    prev_pass = 1'b0;
    @(negedge clk) rst = 1'b0;
    repeat (60) @(negedge clk);
    run(0, 0);

    // start held high: two back-to-back runs.
    mode = 0;
    push(0);
    push(0);
    @(negedge clk) start = 1'b1;
    for (int i = 0; i < 200 && sbq.size() > 1; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_empty();

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
